// File: rtl/thermocouple_pkg.sv
`default_nettype none
// ============================================================================
// Module      : thermocouple_pkg
// Description : Shared types and frame-layout constants for the multi-channel
//               thermocouple scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package thermocouple_pkg;

  // Scanner sequencing states.
  typedef enum logic [2:0] {
    STARTUP = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    CAPTURE = 3'd3,
    SETTLE  = 3'd4
  } state_e;

  // Field positions inside the 32-bit converter frame.
  localparam int TC_MSB  = 31;
  localparam int TC_LSB  = 18;
  localparam int FLT_BIT = 16;
  localparam int JT_MSB  = 15;
  localparam int JT_LSB  = 4;

  localparam int TC_W  = TC_MSB - TC_LSB + 1;
  localparam int JT_W  = JT_MSB - JT_LSB + 1;
  localparam int FLT_W = 4;

  // Fault code written into a channel bank when its transfer never completes.
  localparam logic [FLT_W-1:0] TIMEOUT_CODE = 4'b1000;

endpackage : thermocouple_pkg
`default_nettype wire

// File: rtl/tc_frame_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tc_frame_unpack
// Description : Splits one 32-bit converter frame into thermocouple
//               temperature, cold-junction temperature and fault nibble.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_frame_unpack
  import thermocouple_pkg::*;
(
  input  logic [31:0]      frame_i,
  output logic [TC_W-1:0]  tc_o,
  output logic [JT_W-1:0]  junction_o,
  output logic [FLT_W-1:0] fault_o
);

  // Reserved frame bits carry no information for this block.
  logic w_unused;
  assign w_unused = ^{frame_i[17], frame_i[3]};

  // Raw field copies; no sign extension or scaling.
  assign tc_o       = frame_i[TC_MSB:TC_LSB];
  assign junction_o = frame_i[JT_MSB:JT_LSB];
  assign fault_o    = {frame_i[FLT_BIT], frame_i[2:0]};

endmodule : tc_frame_unpack
`default_nettype wire

// File: rtl/thermocouple_scanner.sv
`default_nettype none
// ============================================================================
// Module      : thermocouple_scanner
// Description : Round-robin scanner for NCH thermocouple converters sharing a
//               single SPI master. Keeps per-channel result banks, gates the
//               temperature update on the frame fault flag, and bounds every
//               transfer with a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module thermocouple_scanner
  import thermocouple_pkg::*;
#(
  parameter int CLK_FREQ    = 800,
  parameter int NCH         = 4,
  parameter int STARTUP_MS  = 3,
  parameter int SETTLE_MS   = 1,
  parameter int TIMEOUT_CYC = 256,
  parameter int CBITS       = 12,
  parameter int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   spi_not_busy,
  input  logic [31:0]            spi_rx_data,
  output logic                   spi_ena,
  output logic [CHW-1:0]         spi_ch_sel,
  output logic [NCH*TC_W-1:0]    tc_temp_data,
  output logic [NCH*JT_W-1:0]    junction_temp_data,
  output logic [NCH*FLT_W-1:0]   fault_bits,
  output logic                   sample_valid,
  output logic [CHW-1:0]         sample_ch,
  output logic                   any_fault,
  output logic                   timeout_err
);

  // Terminal counts; the counter restarts at zero on every state entry, so
  // each phase ends when cnt holds its last value.
  localparam logic [CBITS-1:0] c_startup_last = CBITS'(CLK_FREQ * STARTUP_MS - 1);
  localparam logic [CBITS-1:0] c_settle_last  = CBITS'(CLK_FREQ * SETTLE_MS - 1);
  localparam logic [CBITS-1:0] c_timeout_last = CBITS'(TIMEOUT_CYC - 1);
  localparam logic [CHW-1:0]   c_ch_last      = CHW'(NCH - 1);

  state_e             state_q, state_d;
  logic [CBITS-1:0]   cnt_q, cnt_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic               spi_ena_q, spi_ena_d;
  logic               sample_valid_q, sample_valid_d;
  logic [CHW-1:0]     sample_ch_q;
  logic               timeout_q, timeout_d;
  logic               w_capture;
  logic               w_timeout;

  logic [NCH-1:0][TC_W-1:0]  tc_q;
  logic [NCH-1:0][JT_W-1:0]  jt_q;
  logic [NCH-1:0][FLT_W-1:0] flt_q;

  logic [TC_W-1:0]  w_tc;
  logic [JT_W-1:0]  w_jt;
  logic [FLT_W-1:0] w_flt;

  tc_frame_unpack u_unpack (
    .frame_i    (spi_rx_data),
    .tc_o       (w_tc),
    .junction_o (w_jt),
    .fault_o    (w_flt)
  );

  // Next-state, counter, channel and strobe decode for the scan sequence.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ch_d           = ch_q;
    spi_ena_d      = spi_ena_q;
    sample_valid_d = 1'b0;
    timeout_d      = 1'b0;
    w_capture      = 1'b0;
    w_timeout      = 1'b0;

    case (state_q)
      STARTUP: begin
        if (cnt_q == c_startup_last) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end

      REQ: begin
        if (!enable) begin
          // Idle: no request and no timeout accumulation.
          spi_ena_d = 1'b0;
          cnt_d     = '0;
        end else if (!spi_not_busy) begin
          // Master went busy, so the request was accepted.
          spi_ena_d = 1'b0;
          cnt_d     = '0;
          state_d   = XFER;
        end else if (cnt_q == c_timeout_last) begin
          w_timeout = 1'b1;
          timeout_d = 1'b1;
          spi_ena_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETTLE;
        end else begin
          spi_ena_d = 1'b1;
          cnt_d     = cnt_q + CBITS'(1);
        end
      end

      XFER: begin
        spi_ena_d = 1'b0;
        // Completion is tested first so it wins over a coincident timeout.
        if (spi_not_busy) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else if (cnt_q == c_timeout_last) begin
          w_timeout = 1'b1;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = SETTLE;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end

      CAPTURE: begin
        w_capture      = 1'b1;
        sample_valid_d = 1'b1;
        cnt_d          = '0;
        state_d        = SETTLE;
      end

      SETTLE: begin
        if (cnt_q == c_settle_last) begin
          cnt_d   = '0;
          ch_d    = (ch_q == c_ch_last) ? '0 : ch_q + CHW'(1);
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end

      default: begin
        spi_ena_d = 1'b0;
        cnt_d     = '0;
        state_d   = REQ;
      end
    endcase
  end

  // Sequencer registers and the registered output strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= STARTUP;
      cnt_q          <= '0;
      ch_q           <= '0;
      spi_ena_q      <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ch_q           <= ch_d;
      spi_ena_q      <= spi_ena_d;
      sample_valid_q <= sample_valid_d;
      timeout_q      <= timeout_d;
      if (sample_valid_d) begin
        sample_ch_q <= ch_q;
      end
    end
  end

  // Per-channel result banks; temperatures only take frames without the fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_q  <= '0;
      jt_q  <= '0;
      flt_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (ch_q == CHW'(k)) begin
          if (w_capture) begin
            flt_q[k] <= w_flt;
            if (!w_flt[FLT_W-1]) begin
              tc_q[k] <= w_tc;
              jt_q[k] <= w_jt;
            end
          end else if (w_timeout) begin
            flt_q[k] <= TIMEOUT_CODE;
          end
        end
      end
    end
  end

  assign spi_ena            = spi_ena_q;
  assign spi_ch_sel         = ch_q;
  assign tc_temp_data       = tc_q;
  assign junction_temp_data = jt_q;
  assign fault_bits         = flt_q;
  assign sample_valid       = sample_valid_q;
  assign sample_ch          = sample_ch_q;
  assign timeout_err        = timeout_q;
  assign any_fault          = |flt_q;

endmodule : thermocouple_scanner
`default_nettype wire
